// File: rtl/e10_trace_decoder.sv
// Trace decoder for the e10 controller: maps each sampled y-code to a state,
// checks the transition against the legal successor table and keeps an error count and a tamper alarm.
module e10_trace_decoder #(
  parameter int unsigned ALARM_TH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       smp,
  input  logic       y1,
  input  logic       y2,
  input  logic       y3,
  input  logic       y4,
  input  logic       y5,
  input  logic       y6,
  input  logic       y7,
  input  logic       y8,
  input  logic       y9,
  input  logic       y10,
  input  logic       y11,
  input  logic       y12,
  input  logic       y13,
  input  logic       clr,
  output logic [4:0] st,
  output logic       err,
  output logic       code_err,
  output logic [7:0] err_cnt,
  output logic       alarm
);

  localparam logic [7:0] ALARM_TH8 = ALARM_TH[7:0];

  typedef enum logic [1:0] {CODE_MAP, CODE_13, CODE_ZERO, CODE_BAD} code_kind_e;

  logic [13:1] y;
  assign y = {y13, y12, y11, y10, y9, y8, y7, y6, y5, y4, y3, y2, y1};

  code_kind_e kind;
  logic [4:0] tgt;

  // Literal bit k-1 corresponds to input yk.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    kind = CODE_MAP;
    tgt  = 5'd0;
    unique case (y)
      13'h1100: tgt = 5'd2;
      13'h0003: tgt = 5'd3;
      13'h0110: tgt = 5'd4;
      13'h0017: tgt = 5'd5;
      13'h0440: tgt = 5'd6;
      13'h0170: tgt = 5'd7;
      13'h0140: tgt = 5'd8;
      13'h0001: tgt = 5'd9;
      13'h000D: tgt = 5'd10;
      13'h0002: tgt = 5'd11;
      13'h1010: tgt = 5'd12;
      13'h1030: tgt = 5'd14;
      13'h0A00: tgt = 5'd15;
      13'h0088: tgt = 5'd16;
      13'h1440: tgt = 5'd17;
      13'h0200: tgt = 5'd18;
      13'h1000: kind = CODE_13;
      13'h0000: kind = CODE_ZERO;
      default:  kind = CODE_BAD;
    endcase
  end

  // Bit n of the mask is set when state n is a legal successor.
  function automatic logic [19:0] succ_mask(input logic [4:0] s);
    logic [19:0] m;
    m = 20'h0;
    case (s)
      5'd1:  m = 20'h0003E;
      5'd2:  m = 20'h003D0;
      5'd3:  m = 20'h01C40;
      5'd4:  m = 20'h07C42;
      5'd5:  m = 20'h01140;
      5'd6:  m = 20'h04384;
      5'd7:  m = 20'h00380;
      5'd8:  m = 20'h38000;
      5'd9:  m = 20'h02100;
      5'd10: m = 20'h003A0;
      5'd11: m = 20'h40112;
      5'd12: m = 20'h38000;
      5'd13: m = 20'h80810;
      5'd14: m = 20'h48800;
      5'd15: m = 20'h28400;
      5'd16: m = 20'h00380;
      5'd17: m = 20'h0C4A0;
      5'd18: m = 20'h40112;
      5'd19: m = 20'h40110;
      default: m = 20'h0;
    endcase
    return m;
  endfunction

  logic [4:0] st_d;
  logic       err_d, code_err_d, inc;
  logic [7:0] cnt_base, cnt_d;
  logic       alarm_d;
  logic [19:0] mask;

  always_comb begin
    st_d       = st;
    err_d      = 1'b0;
    code_err_d = 1'b0;
    inc        = 1'b0;
    mask       = succ_mask(st);
    if (smp) begin
      unique case (kind)
        CODE_BAD: begin
          code_err_d = 1'b1;
          st_d       = 5'd0;
        end
        CODE_MAP: begin
          st_d = tgt;
          if (st != 5'd0 && !mask[tgt]) begin
            err_d = 1'b1;
            inc   = 1'b1;
          end
        end
        CODE_13: begin
          if (st == 5'd13)                    st_d = 5'd19;
          else if (st == 5'd4 || st == 5'd9)  st_d = 5'd13;
          else begin
            st_d  = 5'd0;
            err_d = (st != 5'd0);
            inc   = (st != 5'd0);
          end
        end
        CODE_ZERO: begin
          if (st == 5'd4 || st == 5'd11 || st == 5'd18) st_d = 5'd1;
          else if (st == 5'd15)                         st_d = 5'd15;
          else begin
            st_d  = 5'd0;
            err_d = (st != 5'd0);
            inc   = (st != 5'd0);
          end
        end
        default: st_d = st;
      endcase
    end
    // Clear first, then count, so a clear coinciding with an error leaves 1.
    cnt_base = clr ? 8'd0 : err_cnt;
    cnt_d    = (inc && cnt_base != 8'hFF) ? cnt_base + 8'd1 : cnt_base;
    alarm_d  = (alarm & ~clr) | (cnt_d >= ALARM_TH8);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= 5'd1;
      err      <= 1'b0;
      code_err <= 1'b0;
      err_cnt  <= 8'd0;
      alarm    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      st       <= st_d;
      err      <= err_d;
      code_err <= code_err_d;
      err_cnt  <= cnt_d;
      alarm    <= alarm_d;
    end
  end

endmodule

// File: tb/tb_e10_trace_decoder.sv
// Self-checking bench for e10_trace_decoder: directed scenarios plus random codes
// compared against a table-driven reference model; two instances cover ALARM_TH 1 and 3.
module tb_e10_trace_decoder;

  logic clk = 1'b0;
  logic rst, smp, clr;
  logic [13:1] y;

  logic [4:0] st, st3;
  logic       err, err3, code_err, code_err3, alarm, alarm3;
  logic [7:0] err_cnt, err_cnt3;

  always #5 clk = ~clk;

  e10_trace_decoder dut (
    .clk(clk), .rst(rst), .smp(smp),
    .y1(y[1]), .y2(y[2]), .y3(y[3]), .y4(y[4]), .y5(y[5]), .y6(y[6]), .y7(y[7]),
    .y8(y[8]), .y9(y[9]), .y10(y[10]), .y11(y[11]), .y12(y[12]), .y13(y[13]),
    .clr(clr), .st(st), .err(err), .code_err(code_err), .err_cnt(err_cnt), .alarm(alarm)
  );

  e10_trace_decoder #(.ALARM_TH(3)) dut3 (
    .clk(clk), .rst(rst), .smp(smp),
    .y1(y[1]), .y2(y[2]), .y3(y[3]), .y4(y[4]), .y5(y[5]), .y6(y[6]), .y7(y[7]),
    .y8(y[8]), .y9(y[9]), .y10(y[10]), .y11(y[11]), .y12(y[12]), .y13(y[13]),
    .clr(clr), .st(st3), .err(err3), .code_err(code_err3), .err_cnt(err_cnt3), .alarm(alarm3)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int m_st, m_cnt;
  bit m_err, m_cerr, m_al1, m_al3;

  logic [13:1] code_tab[16];
  int          tgt_tab[16];
  int          succ[20][$];

  function automatic logic [13:1] mk(int a = 0, int b = 0, int c = 0, int d = 0);
    logic [13:1] v;
    v = '0;
    if (a != 0) v[a] = 1'b1;
    if (b != 0) v[b] = 1'b1;
    if (c != 0) v[c] = 1'b1;
    if (d != 0) v[d] = 1'b1;
    return v;
  endfunction

  // Returns target, -1 unknown, -2 all-zero, -3 code {13}.
  function automatic int lookup(logic [13:1] c);
    if (c == mk()) return -2;
    if (c == mk(13)) return -3;
    for (int i = 0; i < 16; i++) if (code_tab[i] == c) return tgt_tab[i];
    return -1;
  endfunction

  function automatic bit in_set(int s, int t);
    foreach (succ[s][i]) if (succ[s][i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_st = 1; m_cnt = 0; m_err = 0; m_cerr = 0; m_al1 = 0; m_al3 = 0;
  endtask

  task automatic model_step(logic [13:1] c, bit s, bit cl);
    bit inc;
    int t, r;
    inc = 0;
    m_err = 0;
    m_cerr = 0;
    if (s) begin
      t = lookup(c);
      if (t == -1) begin
        m_cerr = 1;
        m_st = 0;
      end else if (m_st == 0) begin
        m_st = (t > 0) ? t : 0;
      end else begin
        if (t == -3)      r = (m_st == 13) ? 19 : ((m_st == 4 || m_st == 9) ? 13 : -1);
        else if (t == -2) r = (m_st == 4 || m_st == 11 || m_st == 18) ? 1 : ((m_st == 15) ? 15 : -1);
        else              r = in_set(m_st, t) ? t : -1;
        if (r > 0) m_st = r;
        else begin
          m_err = 1;
          inc = 1;
          m_st = (t > 0) ? t : 0;
        end
      end
    end
    if (cl) begin
      m_cnt = 0; m_al1 = 0; m_al3 = 0;
    end
    if (inc && m_cnt < 255) m_cnt++;
    if (m_cnt >= 1) m_al1 = 1;
    if (m_cnt >= 3) m_al3 = 1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".st"}, 32'(st), m_st);
    check({tag, ".err"}, 32'(err), 32'(m_err));
    check({tag, ".code_err"}, 32'(code_err), 32'(m_cerr));
    check({tag, ".err_cnt"}, 32'(err_cnt), m_cnt);
    check({tag, ".alarm"}, 32'(alarm), 32'(m_al1));
    check({tag, ".st_th3"}, 32'(st3), m_st);
    check({tag, ".err_cnt_th3"}, 32'(err_cnt3), m_cnt);
    check({tag, ".alarm_th3"}, 32'(alarm3), 32'(m_al3));
  endtask

  task automatic apply(logic [13:1] c, bit s, bit cl, string tag);
    @(negedge clk);
    y = c; smp = s; clr = cl;
    @(posedge clk);
    model_step(c, s, cl);
    #1 check_all(tag);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    smp = 1'b0; clr = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1 check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [13:1] c;
    int pick;

    code_tab[0]  = mk(9, 13);      tgt_tab[0]  = 2;
    code_tab[1]  = mk(1, 2);       tgt_tab[1]  = 3;
    code_tab[2]  = mk(5, 9);       tgt_tab[2]  = 4;
    code_tab[3]  = mk(1, 2, 3, 5); tgt_tab[3]  = 5;
    code_tab[4]  = mk(7, 11);      tgt_tab[4]  = 6;
    code_tab[5]  = mk(5, 6, 7, 9); tgt_tab[5]  = 7;
    code_tab[6]  = mk(7, 9);       tgt_tab[6]  = 8;
    code_tab[7]  = mk(1);          tgt_tab[7]  = 9;
    code_tab[8]  = mk(1, 3, 4);    tgt_tab[8]  = 10;
    code_tab[9]  = mk(2);          tgt_tab[9]  = 11;
    code_tab[10] = mk(5, 13);      tgt_tab[10] = 12;
    code_tab[11] = mk(5, 6, 13);   tgt_tab[11] = 14;
    code_tab[12] = mk(10, 12);     tgt_tab[12] = 15;
    code_tab[13] = mk(4, 8);       tgt_tab[13] = 16;
    code_tab[14] = mk(7, 11, 13);  tgt_tab[14] = 17;
    code_tab[15] = mk(10);         tgt_tab[15] = 18;
    succ[1]  = '{1, 2, 3, 4, 5};
    succ[2]  = '{4, 6, 7, 8, 9};
    succ[3]  = '{6, 10, 11, 12};
    succ[4]  = '{1, 6, 10, 11, 12, 13, 14};
    succ[5]  = '{6, 8, 12};
    succ[6]  = '{2, 7, 8, 9, 14};
    succ[7]  = '{7, 8, 9};
    succ[8]  = '{15, 16, 17};
    succ[9]  = '{8, 13};
    succ[10] = '{5, 7, 8, 9};
    succ[11] = '{1, 4, 8, 18};
    succ[12] = '{15, 16, 17};
    succ[13] = '{4, 11, 19};
    succ[14] = '{11, 15, 18};
    succ[15] = '{10, 15, 17};
    succ[16] = '{7, 8, 9};
    succ[17] = '{5, 7, 10, 14, 15};
    succ[18] = '{1, 4, 8, 18};
    succ[19] = '{4, 8, 18};

    rst = 1'b0; smp = 1'b0; clr = 1'b0; y = '0;
    model_reset();
    #12 check_all("reset");
    @(negedge clk) rst = 1'b1;

    apply(mk(9, 13), 1, 0, "first_code");
    check("first_code.st_const", 32'(st), 2);

    do_reset("reset_b");
    apply(mk(1, 2), 1, 0, "seq_a1");
    apply(mk(1, 3, 4), 1, 0, "seq_a2");
    apply(mk(5, 9), 1, 0, "seq_a3");
    check("seq_a3.err_const", 32'(err), 1);
    check("seq_a3.cnt_const", 32'(err_cnt), 1);
    check("seq_a3.alarm_const", 32'(alarm), 1);

    do_reset("reset_c");
    apply(mk(5, 9), 1, 0, "y13_a");
    apply(mk(13), 1, 0, "y13_b");
    apply(mk(13), 1, 0, "y13_c");
    check("y13_c.st_const", 32'(st), 19);

    apply(mk(3), 1, 0, "lost_a");
    check("lost_a.code_err_const", 32'(code_err), 1);
    apply(mk(), 1, 0, "lost_b");
    apply(mk(7, 9), 1, 0, "lost_c");
    check("lost_c.st_const", 32'(st), 8);
    apply(mk(1, 2), 0, 0, "hold");

    for (int i = 0; i < 256; i++) apply(mk(7, 9), 1, 0, "sat");
    check("sat.cnt_const", 32'(err_cnt), 255);
    apply(mk(7, 9), 1, 1, "clr_err");
    check("clr_err.cnt_const", 32'(err_cnt), 1);

    for (int i = 0; i < 4; i++) apply(mk(7, 9), 1, 0, "to_five");
    apply(mk(7, 11, 13), 1, 0, "to_17");
    check("to_17.cnt_const", 32'(err_cnt), 5);
    @(posedge clk);
    #3 rst = 1'b0;
    smp = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk) rst = 1'b1;
    apply(mk(1, 2), 1, 0, "restart");

    apply(mk(5, 9), 1, 0, "zero_a");
    apply(mk(), 1, 0, "zero_b");

    for (int i = 0; i < 600; i++) begin
      pick = $urandom_range(0, 19);
      if (pick < 16)       c = code_tab[pick];
      else if (pick == 16) c = mk(13);
      else if (pick == 17) c = mk();
      else                 c = 13'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
      else if ($urandom_range(0, 4) == 0) apply(c, 0, 0, "rnd_idle");
      else apply(c, 1, ($urandom_range(0, 29) == 0), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
